// File: rtl/mi_pkg.sv
// rtl/mi_pkg.sv - shared memory-interface constants and responder FSM states
package mi_pkg;

    localparam int MI_LEN_W = 7;

    localparam logic MI_RW_READ  = 1'b1;
    localparam logic MI_RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_GAP  = 2'd3
    } mi_state_t;

endpackage

// File: rtl/mi_bram_ram.sv
// rtl/mi_bram_ram.sv - simple dual-port 32-bit RAM, sync write, 1-cycle registered read
module mi_bram_ram #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Write port: contents survive reset so aborted bursts keep acked words
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register only moves on a read issue, so it holds between beats
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mi_bram_responder.sv
// rtl/mi_bram_responder.sv - mi bus burst responder backed by on-chip block RAM
module mi_bram_responder
    import mi_pkg::*;
#(
    parameter int AW   = 9,
    parameter int WAIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mi_addr,
    input  logic [MI_LEN_W-1:0] mi_len,
    input  logic                mi_rw,
    input  logic                mi_valid,
    output logic                mi_ready,
    input  logic [31:0]         mi_wdata,
    output logic                mi_wack,
    output logic                mi_wlast,
    output logic [31:0]         mi_rdata,
    output logic                mi_rstb,
    output logic                mi_rlast,
    output logic                busy
);

    localparam logic [3:0] WAIT_RELOAD = 4'((WAIT > 0) ? WAIT - 1 : 0);

    mi_state_t           state, state_n;
    logic [AW-1:0]       ptr, ptr_n;
    logic [MI_LEN_W-1:0] cnt, cnt_n;
    logic [3:0]          wcnt, wcnt_n;
    logic                rw_q, rw_n;
    logic                done, done_n;
    logic                ram_we, ram_re;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^mi_addr[31:AW];

    // Next-state, address/beat counters and RAM strobes.
    // WR and RD are beat cycles; GAP holds wait states, and after the final read
    // issue it covers the cycle in which the last rstb is presented.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        wcnt_n  = wcnt;
        rw_n    = rw_q;
        done_n  = done;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mi_valid && mi_ready) begin
                    ptr_n   = mi_addr[AW-1:0];
                    cnt_n   = mi_len;
                    rw_n    = mi_rw;
                    done_n  = 1'b0;
                    state_n = (mi_rw == MI_RW_READ) ? ST_RD : ST_WR;
                end
            end
            ST_WR: begin
                // A reset landing on a beat must not commit that beat
                ram_we = !rst;
                if (cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    ptr_n = ptr + AW'(1);
                    cnt_n = cnt - MI_LEN_W'(1);
                    if (WAIT > 0) begin
                        state_n = ST_GAP;
                        wcnt_n  = WAIT_RELOAD;
                    end
                end
            end
            ST_RD: begin
                ram_re = 1'b1;
                if (cnt == '0) begin
                    state_n = ST_GAP;
                    done_n  = 1'b1;
                end else begin
                    ptr_n = ptr + AW'(1);
                    cnt_n = cnt - MI_LEN_W'(1);
                    if (WAIT > 0) begin
                        state_n = ST_GAP;
                        wcnt_n  = WAIT_RELOAD;
                    end
                end
            end
            ST_GAP: begin
                if (done) begin
                    state_n = ST_IDLE;
                end else if (wcnt == '0) begin
                    state_n = (rw_q == MI_RW_READ) ? ST_RD : ST_WR;
                end else begin
                    wcnt_n = wcnt - 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            wcnt     <= '0;
            rw_q     <= MI_RW_WRITE;
            done     <= 1'b0;
            mi_ready <= 1'b0;
            busy     <= 1'b0;
            mi_wack  <= 1'b0;
            mi_wlast <= 1'b0;
            mi_rstb  <= 1'b0;
            mi_rlast <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            wcnt     <= wcnt_n;
            rw_q     <= rw_n;
            done     <= done_n;
            mi_ready <= (state_n == ST_IDLE);
            busy     <= (state_n != ST_IDLE);
            mi_wack  <= (state_n == ST_WR);
            mi_wlast <= (state_n == ST_WR) && (cnt_n == '0);
            mi_rstb  <= (state == ST_RD);
            mi_rlast <= (state == ST_RD) && (cnt == '0);
        end
    end

    mi_bram_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ptr),
        .wdata (mi_wdata),
        .re    (ram_re),
        .raddr (ptr),
        .rdata (mi_rdata)
    );

endmodule
